// File: rtl/integer_unit_arbiter.sv
// Round-robin share of one registered integer ALU between two requesters,
// with per-requester one-entry hold buffers for response backpressure.
package integer_unit_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;

endpackage

module integer_unit_arbiter
  import integer_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [1:0][XLEN-1:0] i_req_rs1,
  input  logic [1:0][XLEN-1:0] i_req_rs2,
  input  logic [1:0][XLEN-1:0] i_req_imm,
  input  logic [1:0]           i_req_imm_sel,
  input  logic [1:0][3:0]      i_req_op,
  output logic [1:0]           o_rsp_valid,
  input  logic [1:0]           i_rsp_ready,
  output logic [1:0][XLEN-1:0] o_rsp_data,
  output logic [1:0]           o_rsp_zero,
  output logic [XLEN-1:0]      o_alu_rs1,
  output logic [XLEN-1:0]      o_alu_rs2,
  output logic [XLEN-1:0]      o_alu_imm,
  output logic                 o_alu_imm_sel,
  output logic [3:0]           o_alu_op,
  input  logic [XLEN-1:0]      i_alu_res_data,
  input  logic                 i_alu_res_zero
);

  logic                 last;
  logic                 infl_v;
  logic                 infl_id;
  logic [1:0]           hold_v;
  logic [1:0][XLEN-1:0] hold_data;
  logic [1:0]           hold_zero;

  logic [1:0] own;
  logic [1:0] stall;
  logic [1:0] elig;
  logic [1:0] cand;
  logic       gnt_v;
  logic       g;

  // A stalled result occupies its owner until accepted
  always_comb begin
    own   = '0;
    stall = '0;
    elig  = '0;
    for (int i = 0; i < 2; i++) begin
      own[i]   = infl_v && (infl_id == 1'(i));
      stall[i] = own[i] && !i_rsp_ready[i];
      elig[i]  = !hold_v[i] && !stall[i];
    end
  end

  assign cand  = i_req_valid & elig;
  assign gnt_v = |cand;

  always_comb begin
    g = 1'b0;
    unique case (1'b1)
      (cand == 2'b11): g = ~last;
      (cand == 2'b10): g = 1'b1;
      (cand == 2'b01): g = 1'b0;
      default:         g = 1'b0;
    endcase
  end

  assign o_req_ready[0] = gnt_v && !g;
  assign o_req_ready[1] = gnt_v && g;

  always_comb begin
    o_alu_rs1     = '0;
    o_alu_rs2     = '0;
    o_alu_imm     = '0;
    o_alu_imm_sel = 1'b0;
    o_alu_op      = ALU_ADD;
    if (gnt_v) begin
      o_alu_rs1     = i_req_rs1[g];
      o_alu_rs2     = i_req_rs2[g];
      o_alu_imm     = i_req_imm[g];
      o_alu_imm_sel = i_req_imm_sel[g];
      o_alu_op      = i_req_op[g];
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    o_rsp_zero  = '0;
    for (int i = 0; i < 2; i++) begin
      if (hold_v[i]) begin
        o_rsp_valid[i] = 1'b1;
        o_rsp_data[i]  = hold_data[i];
        o_rsp_zero[i]  = hold_zero[i];
      end else if (own[i]) begin
        o_rsp_valid[i] = 1'b1;
        o_rsp_data[i]  = i_alu_res_data;
        o_rsp_zero[i]  = i_alu_res_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last      <= 1'b1;
      infl_v    <= 1'b0;
      infl_id   <= 1'b0;
      hold_v    <= '0;
      hold_data <= '0;
      hold_zero <= '0;
    end else begin
      infl_v  <= gnt_v;
      infl_id <= g;
      if (gnt_v) begin
        last <= g;
      end
      for (int i = 0; i < 2; i++) begin
        if (stall[i] && !hold_v[i]) begin
          hold_v[i]    <= 1'b1;
          hold_data[i] <= i_alu_res_data;
          hold_zero[i] <= i_alu_res_zero;
        end else if (hold_v[i] && i_rsp_ready[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_integer_unit_arbiter.sv
// Bench for integer_unit_arbiter: random traffic against a queue-level
// model plus directed scenarios with literal expectations.
module tb_integer_unit_arbiter;

  localparam int XLEN = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd7;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][XLEN-1:0] req_rs1;
  logic [1:0][XLEN-1:0] req_rs2;
  logic [1:0][XLEN-1:0] req_imm;
  logic [1:0]           req_imm_sel;
  logic [1:0][3:0]      req_op;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [1:0][XLEN-1:0] rsp_data;
  logic [1:0]           rsp_zero;
  logic [XLEN-1:0]      alu_rs1;
  logic [XLEN-1:0]      alu_rs2;
  logic [XLEN-1:0]      alu_imm;
  logic                 alu_imm_sel;
  logic [3:0]           alu_op;
  logic [XLEN-1:0]      alu_res = '0;
  logic                 alu_zero = 1'b0;

  always #5 clk = ~clk;

  integer_unit_arbiter #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_rs1     (req_rs1),
    .i_req_rs2     (req_rs2),
    .i_req_imm     (req_imm),
    .i_req_imm_sel (req_imm_sel),
    .i_req_op      (req_op),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_data    (rsp_data),
    .o_rsp_zero    (rsp_zero),
    .o_alu_rs1     (alu_rs1),
    .o_alu_rs2     (alu_rs2),
    .o_alu_imm     (alu_imm),
    .o_alu_imm_sel (alu_imm_sel),
    .o_alu_op      (alu_op),
    .i_alu_res_data(alu_res),
    .i_alu_res_zero(alu_zero)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                         logic [3:0] op);
    case (op)
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return {31'd0, $signed(a) < $signed(b)};
      4'd4: return {31'd0, a < b};
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return a + b;
    endcase
  endfunction

  // Registered ALU stand-in; never reset, so stale data survives reset
  always @(posedge clk) begin
    alu_res  <= alu_fn(alu_rs1, alu_imm_sel ? alu_imm : alu_rs2, alu_op);
    alu_zero <= (alu_fn(alu_rs1, alu_imm_sel ? alu_imm : alu_rs2,
                        alu_op) == 32'd0);
  end

  int n_tests = 0;
  int n_fail = 0;

  int          m_cnt[2];
  logic [31:0] m_data[2];
  logic        m_zero[2];
  bit          m_fresh[2];
  bit          m_last;

  logic [1:0]       s_ready;
  logic [1:0]       s_rv;
  logic [1:0][31:0] s_rd;
  logic [1:0]       s_rz;
  bit               s_gv;
  int               s_g;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_data[i]  = '0;
      m_zero[i]  = 1'b0;
      m_fresh[i] = 1'b0;
    end
    m_last = 1'b1;
  endtask

  // One cycle: check outputs against the model, then advance it
  task automatic step();
    bit [1:0]    el;
    bit [1:0]    cand;
    bit          gv;
    int          g;
    logic [31:0] eb;
    #1;
    for (int i = 0; i < 2; i++)
      el[i] = (m_cnt[i] == 0) || (m_fresh[i] && rsp_ready[i]);
    cand = req_valid & el;
    gv = |cand;
    if (cand == 2'b11) g = m_last ? 0 : 1;
    else g = cand[1] ? 1 : 0;
    chk("req_ready", 64'(req_ready), gv ? (g == 1 ? 64'd2 : 64'd1) : 64'd0);
    if (gv) begin
      chk("alu_rs1", 64'(alu_rs1), 64'(req_rs1[g]));
      chk("alu_rs2", 64'(alu_rs2), 64'(req_rs2[g]));
      chk("alu_imm", 64'(alu_imm), 64'(req_imm[g]));
      chk("alu_sel", 64'(alu_imm_sel), 64'(req_imm_sel[g]));
      chk("alu_op", 64'(alu_op), 64'(req_op[g]));
    end else begin
      chk("alu_idle", {alu_rs1, alu_rs2 | alu_imm}, 64'd0);
      chk("alu_idle_op", 64'({alu_imm_sel, alu_op}), 64'(OP_ADD));
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]),
          64'(m_cnt[i] != 0));
      chk($sformatf("rsp_data%0d", i), 64'(rsp_data[i]),
          m_cnt[i] != 0 ? 64'(m_data[i]) : 64'd0);
      chk($sformatf("rsp_zero%0d", i), 64'(rsp_zero[i]),
          m_cnt[i] != 0 ? 64'(m_zero[i]) : 64'd0);
    end
    s_ready = req_ready;
    s_rv    = rsp_valid;
    s_rd    = rsp_data;
    s_rz    = rsp_zero;
    s_gv    = gv;
    s_g     = g;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (m_cnt[i] > 0 && rsp_ready[i]) m_cnt[i]--;
      m_fresh[i] = 1'b0;
    end
    if (gv) begin
      eb = req_imm_sel[g] ? req_imm[g] : req_rs2[g];
      m_data[g]  = alu_fn(req_rs1[g], eb, req_op[g]);
      m_zero[g]  = (m_data[g] == 32'd0);
      m_cnt[g]++;
      m_fresh[g] = 1'b1;
      m_last     = (g == 1);
    end
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data[0] | rsp_data[1]), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic set_op(input int p, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic sel, input logic [3:0] op);
    req_rs1[p]     = a;
    req_rs2[p]     = b;
    req_imm[p]     = im;
    req_imm_sel[p] = sel;
    req_op[p]      = op;
  endtask

  initial begin
    int          gseq[4];
    int          k;
    logic [31:0] got[$];
    rstn        = 1'b0;
    req_valid   = '0;
    rsp_ready   = '0;
    req_rs1     = '0;
    req_rs2     = '0;
    req_imm     = '0;
    req_imm_sel = '0;
    req_op      = '0;
    model_reset();
    do_reset();

    // single op: 5 + 7
    set_op(0, 32'd5, 32'd7, 32'd0, 1'b0, OP_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    step();
    chk("single_valid", 64'(s_rv[0]), 64'd1);
    chk("single_data", 64'(s_rd[0]), 64'd12);
    chk("single_zero", 64'(s_rz[0]), 64'd0);

    // immediate select with arithmetic shift
    set_op(0, 32'h8000_0000, 32'd9, 32'd4, 1'b1, OP_SRA);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    chk("sra_data", 64'(s_rd[0]), 64'hF800_0000);

    // contention after reset: port 0 first, then alternate
    do_reset();
    set_op(0, 32'd3, 32'd3, 32'd0, 1'b0, OP_SUB);
    set_op(1, 32'd5, 32'd3, 32'd0, 1'b0, OP_XOR);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      step();
      gseq[c] = s_gv ? s_g : -1;
      if (c == 1) begin
        chk("cont_p0_valid", 64'(s_rv[0]), 64'd1);
        chk("cont_p0_data", 64'(s_rd[0]), 64'd0);
        chk("cont_p0_zero", 64'(s_rz[0]), 64'd1);
      end
    end
    for (int c = 0; c < 4; c++)
      chk($sformatf("cont_grant%0d", c), 64'(gseq[c]), 64'(c % 2));
    req_valid = 2'b00;
    step();

    // backpressure on port 1 while port 0 streams
    set_op(1, 32'd100, 32'd23, 32'd0, 1'b0, OP_ADD);
    set_op(0, 32'd1, 32'd1, 32'd0, 1'b0, OP_ADD);
    req_valid = 2'b10;
    step();
    req_valid = 2'b11;
    rsp_ready = 2'b01;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_ready", 64'(s_ready), 64'd1);
      chk("bp_held_data", 64'(s_rd[1]), 64'd123);
    end
    rsp_ready = 2'b11;
    step();
    chk("bp_release_valid", 64'(s_rv[1]), 64'd1);
    chk("bp_release_data", 64'(s_rd[1]), 64'd123);
    chk("bp_release_ready", 64'(s_ready), 64'd1);
    req_valid = 2'b01;
    step();
    chk("bp_once", 64'(s_rv[1]), 64'd0);
    req_valid = 2'b00;
    step();

    // reset while a result is in flight
    set_op(0, 32'd9, 32'd9, 32'd0, 1'b0, OP_ADD);
    req_valid = 2'b01;
    step();
    rstn = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    step();
    chk("midrst_no_rsp", 64'(s_rv), 64'd0);
    req_valid = 2'b11;
    step();
    chk("midrst_tie_p0", 64'(s_g), 64'd0);
    req_valid = 2'b00;
    step();

    // ordering with toggling response ready
    k = 0;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      set_op(0, 32'(10 * (k + 1)), 32'd1, 32'd0, 1'b0, OP_ADD);
      req_valid = {1'b0, k < 3};
      rsp_ready = {1'b1, (c % 3) != 1};
      step();
      if (s_gv && s_g == 0) k++;
      if (s_rv[0] && rsp_ready[0]) got.push_back(s_rd[0]);
    end
    chk("order_count", 64'(got.size()), 64'd3);
    for (int j = 0; j < got.size() && j < 3; j++)
      chk($sformatf("order_res%0d", j), 64'(got[j]), 64'(10 * (j + 1) + 1));
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom);
      rsp_ready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
      for (int p = 0; p < 2; p++) begin
        set_op(p,
               $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
               $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
               $urandom, 1'($urandom), 4'($urandom_range(0, 9)));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
